// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream handshake from the serial receiver into the loader
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader assembling big-endian words into instruction memory, then releasing it to the CPU
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader #(
    parameter int AW         = 6,
    parameter int START_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    imem_loader_if.slave        rx,
    input  logic                reload,
    input  logic [AW-1:0]       cpu_a,
    output logic [AW-1:0]       mem_a,
    output logic [31:0]         mem_wd,
    output logic                mem_we,
    output logic                cpu_run,
    output logic                err
);
    localparam logic [AW-1:0] START = AW'(START_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HEADER, DATA, CSUM, RUN, ERROR} state_t;
`else
    typedef enum logic [1:0] {HEADER, DATA, RUN} state_t;
`endif

    state_t        state;
    state_t        state_next;
    logic [1:0]    byte_idx;
    logic [AW:0]   word_cnt;
    logic [AW:0]   n_words;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_addr;
    logic [23:0]   asm_word;
    logic          accept;
    logic          last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    xor_acc;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign rx.rx_ready = (state == HEADER) || (state == DATA) || (state == CSUM);
    assign err         = (state == ERROR);
`else
    assign rx.rx_ready = (state == HEADER) || (state == DATA);
    assign err         = 1'b0;
`endif
    assign accept    = rx.rx_valid && rx.rx_ready;
    assign last_byte = accept && (state == DATA) && (byte_idx == 2'd3);
    // wr_addr holds the address of the word being written, so the write pulse sees a stable address
    assign mem_a     = cpu_run ? cpu_a : wr_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HEADER;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HEADER: if (accept) state_next = DATA;
            DATA: begin
                if (last_byte && (word_cnt + (AW+1)'(1) == n_words)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = RUN;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (accept) state_next = (rx.rx_data == xor_acc) ? RUN : ERROR;
            ERROR: state_next = ERROR;
`endif
            RUN: state_next = RUN;
            default: state_next = HEADER;
        endcase
        if (reload) begin
            state_next = HEADER;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we   <= 1'b0;
            mem_wd   <= 32'h0;
            cpu_run  <= 1'b0;
            byte_idx <= 2'd0;
            word_cnt <= '0;
            n_words  <= (AW+1)'(1);
            wr_ptr   <= START;
            wr_addr  <= START;
            asm_word <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc  <= 8'h00;
`endif
        end else begin
            mem_we  <= 1'b0;
            // Lags RUN by one edge so the final write completes before the CPU owns mem_a
            cpu_run <= (state == RUN) && !reload;
            if (reload) begin
                byte_idx <= 2'd0;
                word_cnt <= '0;
                asm_word <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_acc  <= 8'h00;
`endif
            end else if (accept && (state == HEADER)) begin
                n_words  <= {1'b0, rx.rx_data[AW-1:0]} + (AW+1)'(1);
                wr_ptr   <= START;
                word_cnt <= '0;
                byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_acc  <= 8'h00;
`endif
            end else if (accept && (state == DATA)) begin
                byte_idx <= byte_idx + 2'd1;
                asm_word <= {asm_word[15:0], rx.rx_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_acc  <= xor_acc ^ rx.rx_data;
`endif
                if (last_byte) begin
                    mem_wd   <= {asm_word, rx.rx_data};
                    mem_we   <= 1'b1;
                    wr_addr  <= wr_ptr;
                    wr_ptr   <= wr_ptr + AW'(1);
                    word_cnt <= word_cnt + (AW+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench driving two loaders (START_ADDR 0 and 62) with one byte stream
module tb_imem_loader;
    localparam int AW     = 6;
    localparam int DEPTH  = 64;
    localparam int START1 = 62;

    logic          clk = 1'b0;
    logic          reset;
    logic          reload;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] cpu_a;
    logic [AW-1:0] mem_a0, mem_a1;
    logic [31:0]   mem_wd0, mem_wd1;
    logic          mem_we0, mem_we1, cpu_run0, cpu_run1, err0, err1;

    int tests = 0;
    int fails = 0;

    logic [AW+31:0] q0[$];
    logic [AW+31:0] q1[$];
    logic [31:0]    data_q[$];

    always #5 clk = ~clk;

    imem_loader_if rx0();
    imem_loader_if rx1();
    assign rx0.rx_data  = rx_data;
    assign rx0.rx_valid = rx_valid;
    assign rx1.rx_data  = rx_data;
    assign rx1.rx_valid = rx_valid;

    imem_loader #(.AW(AW), .START_ADDR(0)) dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .reload(reload), .cpu_a(cpu_a),
        .mem_a(mem_a0), .mem_wd(mem_wd0), .mem_we(mem_we0), .cpu_run(cpu_run0), .err(err0)
    );
    imem_loader #(.AW(AW), .START_ADDR(START1)) dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .reload(reload), .cpu_a(cpu_a),
        .mem_a(mem_a1), .mem_wd(mem_wd1), .mem_we(mem_we1), .cpu_run(cpu_run1), .err(err1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected (address, word) pair
    always @(negedge clk) begin
        if (!reset && mem_we0) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write0: got %h expected none", {mem_a0, mem_wd0});
            end else check("write0", {mem_a0, mem_wd0}, q0.pop_front());
        end
        if (!reset && mem_we1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write1: got %h expected none", {mem_a1, mem_wd1});
            end else check("write1", {mem_a1, mem_wd1}, q1.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b, input int stall, input logic rl);
        int g;
        while ($urandom_range(99) < stall) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        reload   = rl;
        g = 0;
        while (!rx0.rx_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (!rx0.rx_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: got rx_ready 0 expected 1");
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) data_q.push_back($urandom);
    endtask

    // Reference: header h loads (h mod 64)+1 words to START+k mod 64, bytes MSB first
    task automatic load(input logic [7:0] hdr, input int stall);
        int n;
        logic [31:0] w;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        n = (int'(hdr) % DEPTH) + 1;
        send_byte(hdr, stall, 1'b0);
        for (int k = 0; k < n; k++) begin
            w = data_q.pop_front();
            q0.push_back({AW'(k % DEPTH), w});
            q1.push_back({AW'((START1 + k) % DEPTH), w});
            for (int j = 0; j < 4; j++) begin
                send_byte(w[31 - 8*j -: 8], stall, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
                x = x ^ w[31 - 8*j -: 8];
`endif
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, stall, 1'b0);
`else
        check("last_we", {mem_we0, mem_we1}, 2'b11);
`endif
        check("run_late", {cpu_run0, cpu_run1}, 2'b00);
        @(posedge clk); #1;
        check("run_on", {cpu_run0, cpu_run1, rx0.rx_ready, rx1.rx_ready}, 4'b1100);
    endtask

    initial begin
        reset = 1'b1; reload = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cpu_a = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_out", {rx0.rx_ready, mem_we0, cpu_run0, err0, mem_wd0}, {4'b1000, 32'h0});
        check("reset_out1", {rx1.rx_ready, mem_we1, cpu_run1, err1}, 4'b1000);

        data_q = '{32'h28020005, 32'h2803000c};
        load(8'h01, 0);
        for (int i = 0; i < 4; i++) begin
            cpu_a = AW'($urandom);
            #1;
            check("cpu_mux", {mem_a0, mem_a1}, {cpu_a, cpu_a});
        end

        // Bytes offered in RUN must not be consumed
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        check("run_hold", {cpu_run0, rx0.rx_ready}, 2'b10);
        rx_valid = 1'b0;
        do_reload();
        check("reload_run", {cpu_run0, cpu_run1, rx0.rx_ready, err0}, 4'b0010);

        fill_random(2);
        load(8'hC1, 30);
        do_reload();
        fill_random(64);
        load(8'h3F, 50);
        do_reload();
        fill_random(4);
        load(8'h03, 20);

        // Reload on the byte-3 edge discards the word
        do_reload();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 0, 1'b0);
        send_byte(8'h44, 0, 1'b1);
        check("reload_b3", {mem_we0, mem_we1, rx0.rx_ready, cpu_run0}, 4'b0010);
        fill_random(2);
        load(8'h01, 10);

        do_reload();
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        pulse_reset();
        check("reset_data", {cpu_run0, rx0.rx_ready, mem_we0}, 3'b010);
        fill_random(1);
        load(8'h00, 0);
        pulse_reset();
        check("reset_run", {cpu_run0, cpu_run1, rx0.rx_ready, mem_we0}, 4'b0010);

`ifdef IMEM_LOADER_CHECKSUM_EN
        data_q = '{32'h28020005};
        load(8'h00, 0);
        do_reload();
        send_byte(8'h00, 0, 1'b0);
        q0.push_back({AW'(0), 32'h28020005});
        q1.push_back({AW'(START1), 32'h28020005});
        send_byte(8'h28, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        @(posedge clk); #1;
        check("csum_err", {err0, cpu_run0, rx0.rx_ready}, 3'b100);
        do_reload();
        check("csum_clr", {err0, rx0.rx_ready}, 2'b01);
`else
        check("err_tied", {err0, err1}, 2'b00);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("drain0", q0.size(), 0);
        check("drain1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
